// File: rtl/vga_pkg.sv
// Shared definitions for the VGA layer compositor.
//   - Default 640x480@60 timing constants (active/front porch/sync/back porch).
//   - line_total(): derives H_TOTAL / V_TOTAL from the four timing segments.
//   - layer_w():    width of one packed {r,g,b} layer slice.
//   - sel_w():      width of a layer index, never less than one bit.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int line_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int layer_w(input int color_w);
    return 3 * color_w;
  endfunction

  function automatic int sel_w(input int num_layers);
    return (num_layers > 1) ? $clog2(num_layers) : 1;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing generator: pixel prescaler, horizontal/vertical counters and
// undelayed sync/active flags.
// Ports:
//   clock, reset            sole clock, synchronous active-high reset
//   pix_en                  registered pixel strobe, 1 cycle in CLK_DIV
//   hcount, vcount          current raster position
//   hsync_raw, vsync_raw    active-low sync for the current position
//   active_raw              current position lies in the visible area
//   line_start, frame_start pulse in the strobe cycle where hcount (and
//                           vcount) wrap to 0
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clock,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       active_raw,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [PW-1:0] presc_q, presc_d;
  logic          pix_en_q, pix_en_d;
  logic [9:0]    hcount_q, hcount_d;
  logic [9:0]    vcount_q, vcount_d;
  logic          h_wrap, v_wrap;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    presc_d  = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    // Strobe is registered: high in the cycle after the prescaler hits its
    // last value, which with CLK_DIV=1 keeps it permanently high.
    pix_en_d = (presc_q == PRESC_LAST);
    h_wrap   = (hcount_q == H_LAST);
    v_wrap   = (vcount_q == V_LAST);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en_q) begin
      hcount_d = h_wrap ? '0 : hcount_q + 10'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + 10'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q  <= '0;
      pix_en_q <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      presc_q  <= presc_d;
      pix_en_q <= pix_en_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign line_start  = pix_en_q && h_wrap;
  assign frame_start = line_start && v_wrap;
  assign hsync_raw   = !((hcount_q >= HS_START) && (hcount_q < HS_END));
  assign vsync_raw   = !((vcount_q >= VS_START) && (vcount_q < VS_END));
  assign active_raw  = (hcount_q < 10'(H_ACTIVE)) && (vcount_q < 10'(V_ACTIVE));

endmodule

// File: rtl/vga_layer_compositor.sv
// VGA layer compositor: drives raster timing and composites NUM_LAYERS
// colour layers by priority (lowest index wins among opaque layers) or by a
// forced layer index.
// Ports:
//   clock, reset              sole clock, synchronous active-high reset
//   layer_rgb                 layer i at [i*3*COLOR_W +: 3*COLOR_W], {r,g,b}
//   layer_en                  per-layer enable, 0 = transparent
//   force_en, force_sel       show only layer force_sel (black if out of range)
//   pix_en                    pixel strobe
//   hcount, vcount            current raster position
//   red, green, blue          registered composited pixel
//   hsync, vsync              registered active-low syncs, aligned with colour
//   frame_start, line_start   single-cycle raster pulses
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int COLOR_W    = 1,
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  localparam int LAYER_W   = layer_w(COLOR_W),
  localparam int SEL_W     = sel_w(NUM_LAYERS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_LAYERS*LAYER_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic                          force_en,
  input  logic [SEL_W-1:0]              force_sel,
  output logic                          pix_en,
  output logic [9:0]                    hcount,
  output logic [9:0]                    vcount,
  output logic [COLOR_W-1:0]            red,
  output logic [COLOR_W-1:0]            green,
  output logic [COLOR_W-1:0]            blue,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          frame_start,
  output logic                          line_start
);

  logic hsync_raw, vsync_raw, active_raw;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .pix_en      (pix_en),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .active_raw  (active_raw),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  // Two-strobe delay: stage 1 holds the flags of the pixel whose colour the
  // layer sources are registering now; the output registers form stage 2 and
  // take that pixel's flags together with its colour.
  logic               hs_s1_q, vs_s1_q, act_s1_q;
  logic               hsync_q, vsync_q;
  logic [LAYER_W-1:0] rgb_q, rgb_d;
  logic [LAYER_W-1:0] pick;
  logic               found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    if (force_en) begin
      // Out-of-range indices match no layer and leave the pixel black.
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (force_sel == SEL_W'(i)) begin
          pick = layer_rgb[i*LAYER_W +: LAYER_W];
        end
      end
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (!found && layer_en[i] && (|layer_rgb[i*LAYER_W +: LAYER_W])) begin
          pick  = layer_rgb[i*LAYER_W +: LAYER_W];
          found = 1'b1;
        end
      end
    end
    rgb_d = act_s1_q ? pick : '0;
  end

  // Syncs reset to their inactive level so no pulse leaks out of the pipe
  // in the first strobes after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_s1_q  <= 1'b1;
      vs_s1_q  <= 1'b1;
      act_s1_q <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      rgb_q    <= '0;
    end else if (pix_en) begin
      hs_s1_q  <= hsync_raw;
      vs_s1_q  <= vsync_raw;
      act_s1_q <= active_raw;
      hsync_q  <= hs_s1_q;
      vsync_q  <= vs_s1_q;
      rgb_q    <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign red   = rgb_q[LAYER_W-1 -: COLOR_W];
  assign green = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench for vga_layer_compositor. Two instances share clock
// and reset: A (8 layers, 1-bit colour, CLK_DIV=4) and B (3 layers, 2-bit
// colour, CLK_DIV=1), both on a reduced 24x12 raster to keep frames short.
module tb_vga_layer_compositor;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int DA = 4;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A
  logic [23:0] a_rgb;
  logic [7:0]  a_en;
  logic        a_fen;
  logic [2:0]  a_fsel;
  logic        a_pix, a_hs, a_vs, a_fs, a_ls;
  logic [9:0]  a_h, a_v;
  logic        a_r, a_g, a_b;

  // Instance B
  logic [17:0] b_rgb;
  logic [2:0]  b_en;
  logic        b_fen;
  logic [1:0]  b_fsel;
  logic        b_pix, b_hs, b_vs, b_fs, b_ls;
  logic [9:0]  b_h, b_v;
  logic [1:0]  b_r, b_g, b_b;

  vga_layer_compositor #(
    .NUM_LAYERS(8), .COLOR_W(1), .CLK_DIV(DA),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut_a (
    .clock(clk), .reset(rst), .layer_rgb(a_rgb), .layer_en(a_en),
    .force_en(a_fen), .force_sel(a_fsel), .pix_en(a_pix),
    .hcount(a_h), .vcount(a_v), .red(a_r), .green(a_g), .blue(a_b),
    .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs), .line_start(a_ls)
  );

  vga_layer_compositor #(
    .NUM_LAYERS(3), .COLOR_W(2), .CLK_DIV(DB),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut_b (
    .clock(clk), .reset(rst), .layer_rgb(b_rgb), .layer_en(b_en),
    .force_en(b_fen), .force_sel(b_fsel), .pix_en(b_pix),
    .hcount(b_h), .vcount(b_v), .red(b_r), .green(b_g), .blue(b_b),
    .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs), .line_start(b_ls)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference raster model, indexed by linear pixel position within a frame.
  function automatic bit act_at(input int p);
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction
  function automatic bit hs_at(input int p);
    int h = p % HT;
    return !((h >= HA + HF) && (h < HA + HF + HS));
  endfunction
  function automatic bit vs_at(input int p);
    int v = p / HT;
    return !((v >= VA + VF) && (v < VA + VF + VS));
  endfunction

  // Checks one instance at cycle j after reset release (j=1 is the first
  // negedge after the first edge that samples reset low).
  task automatic check_cycle(input string tag, input int d, input int j,
                             input logic pix, input logic [9:0] h, input logic [9:0] v,
                             input logic [5:0] rgb, input logic [5:0] rgb_on,
                             input logic hs, input logic vs, input logic fs, input logic ls,
                             input int fs_last, output int fs_last_o);
    int k, p, dp;
    bit pe, e_hs, e_vs, e_ls;
    logic [5:0] e_rgb;
    k  = (j - 1) / d;          // strobe edges completed so far
    p  = k % FR;
    pe = (j % d) == 0;
    if (k < 2) begin
      e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
    end else begin
      dp    = (k - 2) % FR;
      e_hs  = hs_at(dp);
      e_vs  = vs_at(dp);
      e_rgb = act_at(dp) ? rgb_on : 6'd0;
    end
    e_ls = pe && ((p % HT) == HT - 1);
    check({tag, "_pix_en"}, pix, pe);
    check({tag, "_hcount"}, h, p % HT);
    check({tag, "_vcount"}, v, p / HT);
    check({tag, "_rgb"}, rgb, e_rgb);
    check({tag, "_hsync"}, hs, e_hs);
    check({tag, "_vsync"}, vs, e_vs);
    check({tag, "_line_start"}, ls, e_ls);
    check({tag, "_frame_start"}, fs, e_ls && ((p / HT) == VT - 1));
    fs_last_o = fs_last;
    if (fs) begin
      if (fs_last < 0) check({tag, "_first_frame_clk"}, j, FR * d);
      else             check({tag, "_frame_period"}, j - fs_last, FR * d);
      fs_last_o = j;
    end
  endtask

  // Caller has just dropped reset at a negedge.
  task automatic sweep(input int ncyc);
    int fa = -1, fb = -1;
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      check_cycle("a", DA, j, a_pix, a_h, a_v, {3'b0, a_r, a_g, a_b}, 6'h07,
                  a_hs, a_vs, a_fs, a_ls, fa, fa);
      check_cycle("b", DB, j, b_pix, b_h, b_v, {b_r, b_g, b_b}, 6'h3f,
                  b_hs, b_vs, b_fs, b_ls, fb, fb);
    end
  endtask

  task automatic check_reset_state();
    check("rst_a_pix", a_pix, 0);
    check("rst_a_pos", {a_h, a_v}, 0);
    check("rst_a_rgb", {a_r, a_g, a_b}, 0);
    check("rst_a_sync", {a_hs, a_vs}, 2'b11);
    check("rst_a_pulses", {a_fs, a_ls}, 0);
    check("rst_b_pix", b_pix, 0);
    check("rst_b_pos", {b_h, b_v}, 0);
    check("rst_b_rgb", {b_r, b_g, b_b}, 0);
    check("rst_b_sync", {b_hs, b_vs}, 2'b11);
    check("rst_b_pulses", {b_fs, b_ls}, 0);
  endtask

  // Stop at a strobe cycle whose next sample lands on a visible pixel with
  // at least one more visible pixel after it.
  task automatic wait_a();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_pix && a_h >= 1 && a_h <= 14 && a_v < VA) && n < 3000);
    if (n >= 3000) check("a_wait_timeout", 0, 1);
  endtask

  task automatic wait_b();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(b_pix && b_h >= 1 && b_h <= 14 && b_v < VA) && n < 3000);
    if (n >= 3000) check("b_wait_timeout", 0, 1);
  endtask

  function automatic logic [23:0] la(input int i, input logic [2:0] c);
    return 24'(c) << (3 * i);
  endfunction
  function automatic logic [17:0] lb(input int i, input logic [5:0] c);
    return 18'(c) << (6 * i);
  endfunction

  typedef struct {
    string       name;
    logic [7:0]  en;
    logic        fen;
    logic [2:0]  fsel;
    logic [23:0] rgb;
    logic [2:0]  exp;
  } vec_a_t;

  typedef struct {
    string       name;
    logic [2:0]  en;
    logic        fen;
    logic [1:0]  fsel;
    logic [17:0] rgb;
    logic [5:0]  exp;
  } vec_b_t;

  vec_a_t va[10];
  vec_b_t vb[7];

  initial begin
    va[0] = '{"a_prio_2_over_5",   8'hff, 1'b0, 3'd0, la(2, 3'b100) | la(5, 3'b100), 3'b100};
    va[1] = '{"a_prio_2_vs_5",     8'hff, 1'b0, 3'd0, la(2, 3'b100) | la(5, 3'b010), 3'b100};
    va[2] = '{"a_en2_cleared",     8'hfb, 1'b0, 3'd0, la(2, 3'b100) | la(5, 3'b010), 3'b010};
    va[3] = '{"a_none_enabled",    8'h00, 1'b0, 3'd0, la(0, 3'b111) | la(4, 3'b011), 3'b000};
    va[4] = '{"a_all_transparent", 8'hff, 1'b0, 3'd0, 24'h0,                         3'b000};
    va[5] = '{"a_top_layer_only",  8'hff, 1'b0, 3'd0, la(7, 3'b011),                 3'b011};
    va[6] = '{"a_layer0_wins",     8'hff, 1'b0, 3'd0, la(0, 3'b111) | la(3, 3'b001), 3'b111};
    va[7] = '{"a_layer0_disabled", 8'hfe, 1'b0, 3'd0, la(0, 3'b111) | la(3, 3'b001), 3'b001};
    va[8] = '{"a_force_clear_5",   8'hff, 1'b1, 3'd5, la(0, 3'b111),                 3'b000};
    va[9] = '{"a_force_7_no_en",   8'h00, 1'b1, 3'd7, la(7, 3'b110) | la(1, 3'b001), 3'b110};

    vb[0] = '{"b_prio_1",         3'b111, 1'b0, 2'd0, lb(1, 6'h2a) | lb(2, 6'h15), 6'h2a};
    vb[1] = '{"b_en1_cleared",    3'b101, 1'b0, 2'd0, lb(1, 6'h2a) | lb(2, 6'h15), 6'h15};
    vb[2] = '{"b_force_oob",      3'b111, 1'b1, 2'd3, lb(0, 6'h3f) | lb(1, 6'h01), 6'h00};
    vb[3] = '{"b_force_clear_2",  3'b111, 1'b1, 2'd2, lb(0, 6'h3f),                6'h00};
    vb[4] = '{"b_force_1_no_en",  3'b000, 1'b1, 2'd1, lb(1, 6'h01),                6'h01};
    vb[5] = '{"b_top_layer_only", 3'b111, 1'b0, 2'd0, lb(2, 6'h30),                6'h30};
    vb[6] = '{"b_blue_only_opq",  3'b111, 1'b0, 2'd0, lb(0, 6'h03) | lb(1, 6'h30), 6'h03};

    // Layer 0 fully lit: visible area shows all ones, blanking shows black.
    a_rgb = la(0, 3'b111); a_en = 8'hff; a_fen = 1'b0; a_fsel = '0;
    b_rgb = lb(0, 6'h3f);  b_en = 3'b111; b_fen = 1'b0; b_fsel = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    sweep(2 * FR * DA + 8);

    // Mid-frame reset held for 3 clocks, then a fresh start from 0,0.
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(a_h == 10'd10 && a_v == 10'd5) && n < 2 * FR * DA);
      check("a_midframe_reached", {a_h, a_v}, {10'd10, 10'd5});
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_state();
    end
    rst = 1'b0;
    sweep(3 * HT * DA);

    // Composition vectors: drive at a strobe cycle, read after the edge.
    for (int i = 0; i < 10; i++) begin
      wait_a();
      a_en = va[i].en; a_fen = va[i].fen; a_fsel = va[i].fsel; a_rgb = va[i].rgb;
      @(negedge clk);
      check(va[i].name, {a_r, a_g, a_b}, va[i].exp);
    end
    for (int i = 0; i < 7; i++) begin
      wait_b();
      b_en = vb[i].en; b_fen = vb[i].fen; b_fsel = vb[i].fsel; b_rgb = vb[i].rgb;
      @(negedge clk);
      check(vb[i].name, {b_r, b_g, b_b}, vb[i].exp);
    end

    // Mid-pixel input change: output holds until the next strobe samples it.
    wait_a();
    a_en = 8'hff; a_fen = 1'b0; a_rgb = la(3, 3'b101);
    @(negedge clk);
    check("a_hold_first", {a_r, a_g, a_b}, 3'b101);
    a_rgb = la(3, 3'b010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("a_hold_between", {a_r, a_g, a_b}, 3'b101);
    end
    @(negedge clk);
    check("a_hold_update", {a_r, a_g, a_b}, 3'b010);

    // Force switched off mid-pixel takes effect on the next sample only.
    wait_a();
    a_en = 8'hff; a_fen = 1'b1; a_fsel = 3'd4; a_rgb = la(1, 3'b001) | la(4, 3'b110);
    @(negedge clk);
    check("a_force_4", {a_r, a_g, a_b}, 3'b110);
    a_fen = 1'b0;
    @(negedge clk);
    check("a_force_held", {a_r, a_g, a_b}, 3'b110);
    repeat (3) @(negedge clk);
    check("a_force_released", {a_r, a_g, a_b}, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
